// File: rtl/enigma_stream_ctrl.sv
// Byte-stream front-end for the enigma core: input FIFO, one-at-a-time core issue,
// watchdog on every core transaction, and a single-entry ready/valid output slot.
module enigma_stream_ctrl #(
   parameter int unsigned FIFO_DEPTH     = 4,
   parameter int unsigned TIMEOUT_CYCLES = 256,
   parameter int unsigned CASE_RESTORE   = 1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        clr,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [7:0]  in_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [7:0]  out_data,
   output logic        core_valid,
   output logic [7:0]  core_din,
   input  logic        core_done,
   input  logic [7:0]  core_dout,
   output logic        busy,
   output logic        err,
   output logic [15:0] char_cnt
);

   localparam int unsigned PtrW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CntW   = PtrW + 1;
   localparam int unsigned TimerW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CntW-1:0]   FifoFull  = CntW'(FIFO_DEPTH);
   localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

   state_e            state_q;
   logic [7:0]        mem_q [FIFO_DEPTH];
   logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0]   count_q, count_d;
   logic              in_ready_q;
   logic              core_valid_q;
   logic [7:0]        core_din_q;
   logic              upper_q;
   logic [TimerW-1:0] timer_q;
   logic              out_valid_q;
   logic [7:0]        out_data_q;
   logic              err_q;
   logic [15:0]       char_cnt_q;

   logic       fifo_empty, push, pop, slot_free, head_lower, head_upper;
   logic [7:0] head;

   assign fifo_empty = (count_q == '0);
   assign push       = in_valid && in_ready_q;
   assign slot_free  = !out_valid_q || out_ready;
   assign pop        = (state_q == StIdle) && !fifo_empty && slot_free;
   assign head       = mem_q[rd_ptr_q];
   assign head_lower = (head >= 8'h61) && (head <= 8'h7A);
   assign head_upper = (head >= 8'h41) && (head <= 8'h5A);

   always_comb begin
      count_d = count_q;
      if (push && !pop) begin
         count_d = count_q + CntW'(1);
      end else if (!push && pop) begin
         count_d = count_q - CntW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= in_data;
      end
   end

   // in_ready is registered so it stays low until the first edge after reset release
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         in_ready_q <= 1'b0;
      end else if (clr) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         in_ready_q <= 1'b1;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + PtrW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PtrW'(1);
         end
         count_q    <= count_d;
         in_ready_q <= (count_d != FifoFull);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= StIdle;
         core_valid_q <= 1'b0;
         core_din_q   <= '0;
         upper_q      <= 1'b0;
         timer_q      <= '0;
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         err_q        <= 1'b0;
         char_cnt_q   <= '0;
      end else if (clr) begin
         state_q      <= StIdle;
         core_valid_q <= 1'b0;
         upper_q      <= 1'b0;
         timer_q      <= '0;
         out_valid_q  <= 1'b0;
         err_q        <= 1'b0;
         char_cnt_q   <= '0;
      end else begin
         // drain first; a reload on the same edge below takes precedence
         if (out_ready) begin
            out_valid_q <= 1'b0;
         end
         core_valid_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (pop) begin
                  if (head_lower || head_upper) begin
                     core_din_q   <= head | 8'h20;
                     upper_q      <= head_upper;
                     core_valid_q <= 1'b1;
                     state_q      <= StIssue;
                  end else begin
                     out_valid_q <= 1'b1;
                     out_data_q  <= head;
                  end
               end
            end
            StIssue: begin
               timer_q <= '0;
               state_q <= StWait;
            end
            StWait: begin
               if (core_done) begin
                  out_valid_q <= 1'b1;
                  out_data_q  <= (upper_q && (CASE_RESTORE != 0)) ? (core_dout & 8'hDF)
                                                                   : core_dout;
                  char_cnt_q  <= char_cnt_q + 16'd1;
                  state_q     <= StIdle;
               end else if (timer_q == TimerLast) begin
                  out_valid_q <= 1'b1;
                  out_data_q  <= 8'h3F;
                  err_q       <= 1'b1;
                  char_cnt_q  <= char_cnt_q + 16'd1;
                  state_q     <= StIdle;
               end else begin
                  timer_q <= timer_q + TimerW'(1);
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign in_ready   = in_ready_q;
   assign out_valid  = out_valid_q;
   assign out_data   = out_data_q;
   assign core_valid = core_valid_q;
   assign core_din   = core_din_q;
   assign err        = err_q;
   assign char_cnt   = char_cnt_q;
   assign busy       = (state_q != StIdle) || !fifo_empty;

endmodule

// File: tb/tb_enigma_stream_ctrl.sv
// Directed bench for enigma_stream_ctrl with a 5-cycle core model (dout = din + 1).
// A second instance with CASE_RESTORE=0 runs in lockstep for the case-fold check.
module tb_enigma_stream_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_n, clr, in_valid, out_ready;
   logic [7:0]  in_data;
   logic        core_done;
   logic [7:0]  core_dout;

   logic        in_ready, out_valid, core_valid, busy, err;
   logic [7:0]  out_data, core_din;
   logic [15:0] char_cnt;

   logic        in_ready2, out_valid2, core_valid2, busy2, err2;
   logic [7:0]  out_data2, core_din2;
   logic [15:0] char_cnt2;

   enigma_stream_ctrl #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(16), .CASE_RESTORE(1)) dut (
      .clk(clk), .reset_n(reset_n), .clr(clr),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .core_valid(core_valid), .core_din(core_din),
      .core_done(core_done), .core_dout(core_dout),
      .busy(busy), .err(err), .char_cnt(char_cnt)
   );

   enigma_stream_ctrl #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(16), .CASE_RESTORE(0)) dut2 (
      .clk(clk), .reset_n(reset_n), .clr(clr),
      .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
      .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
      .core_valid(core_valid2), .core_din(core_din2),
      .core_done(core_done), .core_dout(core_dout),
      .busy(busy2), .err(err2), .char_cnt(char_cnt2)
   );

   // core model
   bit         core_en = 1'b1;
   logic [4:0] dly = '0;
   logic [7:0] core_lat = '0;
   always @(posedge clk) begin
      dly <= {dly[3:0], core_valid && core_en};
      if (core_valid) core_lat <= core_din;
   end
   assign core_done = dly[4];
   assign core_dout = core_lat + 8'd1;

   // monitor
   int         cyc = 0;
   int         cv_cyc = 0, ov_cyc = 0;
   logic       ov_prev = 1'b0;
   logic [7:0] outq[$], out2q[$], dinq[$];
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) begin
      if (out_valid && out_ready) outq.push_back(out_data);
      if (out_valid2 && out_ready) out2q.push_back(out_data2);
      if (core_valid) begin
         dinq.push_back(core_din);
         cv_cyc <= cyc;
      end
      if (out_valid && !ov_prev) ov_cyc <= cyc;
      ov_prev <= out_valid;
   end

   int total = 0, bad = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   task automatic clear_q();
      outq.delete();
      out2q.delete();
      dinq.delete();
   endtask

   task automatic push(input logic [7:0] b);
      int n = 0;
      in_valid = 1'b1;
      in_data  = b;
      @(negedge clk);
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) check("push_timeout", in_ready, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while ((busy || out_valid) && n < 500);
      check("idle_timeout", busy || out_valid, 0);
      @(posedge clk);
      #1;
   endtask

   task automatic wait_cv();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!core_valid && n < 100);
      check("core_valid_timeout", core_valid, 1);
   endtask

   task automatic clr_pulse();
      clr = 1'b1;
      @(posedge clk);
      #1;
      clr = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n;
      reset_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
      #12;
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_core_valid", core_valid, 0);
      check("rst_core_din", core_din, 0);
      check("rst_char_cnt", char_cnt, 0);
      check("rst_err_busy", {err, busy}, 0);
      check("rst_dut2", {in_ready2, out_valid2, core_valid2, busy2, err2, core_din2, char_cnt2},
            0);
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      check("rel_in_ready_low", in_ready, 0);
      @(posedge clk);
      #1;
      check("rel_in_ready_high", in_ready, 1);

      // Test 1: single lowercase letter
      clear_q();
      push(8'h61);
      wait_idle();
      check("t1_ncore", dinq.size(), 1);
      check("t1_core_din", dinq[0], 8'h61);
      check("t1_nout", outq.size(), 1);
      check("t1_out", outq[0], 8'h62);
      check("t1_latency", ov_cyc - cv_cyc, 6);
      check("t1_char_cnt", char_cnt, 1);
      check("t1_err", err, 0);

      // Test 2: mixed case and bypass characters
      clr_pulse();
      clear_q();
      push(8'h48); push(8'h20); push(8'h69); push(8'h21);
      wait_idle();
      check("t2_nout", outq.size(), 4);
      check("t2_out0", outq[0], 8'h49);
      check("t2_out1", outq[1], 8'h20);
      check("t2_out2", outq[2], 8'h6A);
      check("t2_out3", outq[3], 8'h21);
      check("t2_ncore", dinq.size(), 2);
      check("t2_din0", dinq[0], 8'h68);
      check("t2_din1", dinq[1], 8'h69);
      check("t2_char_cnt", char_cnt, 2);
      check("t2_norestore0", out2q[0], 8'h69);
      check("t2_norestore2", out2q[2], 8'h6A);

      // Test 3: backpressure fills the FIFO behind a stalled slot
      clr_pulse();
      clear_q();
      out_ready = 1'b0;
      push(8'h62);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!out_valid && n < 100);
      check("t3_stall_valid", out_valid, 1);
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) push(8'h63 + 8'(i));
      repeat (3) @(negedge clk);
      check("t3_in_ready_low", in_ready, 0);
      check("t3_hold_valid", out_valid, 1);
      check("t3_hold_data", out_data, 8'h63);
      check("t3_busy", busy, 1);
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      push(8'h67);
      wait_idle();
      check("t3_nout", outq.size(), 6);
      for (int i = 0; i < 6; i++) check("t3_out", outq[i], 8'h63 + 32'(i));

      // Test 4: watchdog timeout, then normal recovery
      clr_pulse();
      clear_q();
      core_en = 1'b0;
      push(8'h70);
      wait_idle();
      check("t4_timeout_out", outq[0], 8'h3F);
      check("t4_timeout_lat", ov_cyc - cv_cyc, 17);
      check("t4_err", err, 1);
      check("t4_cnt1", char_cnt, 1);
      core_en = 1'b1;
      push(8'h71);
      wait_idle();
      check("t4_next_out", outq[1], 8'h72);
      check("t4_err_sticky", err, 1);
      check("t4_cnt2", char_cnt, 2);

      // Test 5: clr during WAIT, core answers two cycles later
      clear_q();
      push(8'h6B);
      wait_cv();
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      clr_pulse();
      repeat (8) @(negedge clk);
      check("t5_nout", outq.size(), 0);
      check("t5_out_valid", out_valid, 0);
      check("t5_busy", busy, 0);
      check("t5_err", err, 0);
      check("t5_char_cnt", char_cnt, 0);
      @(posedge clk);
      #1;

      // Test 6: async reset while in ISSUE
      push(8'h6D);
      wait_cv();
      #2;
      reset_n = 1'b0;
      #1;
      check("t6_core_valid", core_valid, 0);
      check("t6_core_din", core_din, 0);
      check("t6_outs", {out_valid, busy, in_ready, err}, 0);
      check("t6_char_cnt", char_cnt, 0);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      check("t6_fifo_empty", busy, 0);
      clear_q();
      push(8'h7A);
      wait_idle();
      check("t6_nout", outq.size(), 1);
      check("t6_out", outq[0], 8'h7B);
      check("t6_char_cnt_after", char_cnt, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
